// File: rtl/sequence_round_ctrl_pkg.sv
// Shared definitions for the game-round controller and the sequence generator:
// controller state encoding, default RAM geometry and a small sizing helper.
package sequence_round_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [3:0] {
    IDLE,
    GEN,
    SHOW_RD,
    SHOW_LAT,
    SHOW_ON,
    SHOW_GAP,
    IN_RD,
    IN_WAIT,
    ROUND_END
  } state_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sequence_round_ctrl_timer.sv
// Loadable down-counter shared by the show, gap and input-timeout intervals.
// Expired is high while the count sits at zero; load wins over enable.
module round_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  input  logic         i_enable,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/sequence_round_ctrl.sv
// Game-round controller: triggers pattern generation, plays back the first N
// nibbles, collects N player entries and grows N until a win or a loss.
module sequence_round_ctrl
  import sequence_round_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_LEN     = 32,
  parameter int SHOW_CYC    = 24,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              gen_start,
  input  logic              gen_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_value,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_value,
  output logic [ADDR_W:0]   round,
  output logic              busy,
  output logic              win,
  output logic              lose
);

  localparam int TMAX = maxOf3(SHOW_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  // Intervals load N-1 so that the zero-count cycle is the last one of the interval.
  localparam logic [TW-1:0]   SHOW_LOAD = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0]   GAP_LOAD  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]   TO_LOAD   = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W:0] MAX_ROUND = (ADDR_W + 1)'(MAX_LEN);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_round;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_expected;
  logic              r_inFirst;
  logic              r_genStart;
  logic              r_win;
  logic              r_lose;

  logic              w_expired;
  logic              w_timeout;
  logic              w_lastIdx;
  logic              w_inMatch;
  logic [DATA_W-1:0] w_expected;
  logic              w_timerLoad;
  logic [TW-1:0]     w_timerLoadValue;
  logic              w_timerEnable;

  // RAM data is only valid in the first IN_WAIT cycle, so it is used directly then and held afterwards.
  assign w_expected = r_inFirst ? mem_rdata : r_expected;
  assign w_inMatch  = (in_value == w_expected);
  assign w_lastIdx  = ({1'b0, r_idx} == (r_round - 1'b1));
  assign w_timeout  = (TIMEOUT_CYC != 0) && w_expired;

  round_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timerLoad),
    .i_loadValue(w_timerLoadValue),
    .i_enable   (w_timerEnable),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (start) w_nextState = GEN;
      GEN:       if (gen_finish) w_nextState = SHOW_RD;
      SHOW_RD:   w_nextState = SHOW_LAT;
      SHOW_LAT:  w_nextState = SHOW_ON;
      SHOW_ON:   if (w_expired) w_nextState = SHOW_GAP;
      SHOW_GAP:  if (w_expired) w_nextState = w_lastIdx ? IN_RD : SHOW_RD;
      IN_RD:     w_nextState = IN_WAIT;
      IN_WAIT: begin
        // A player entry takes priority over a timeout expiring in the same cycle.
        if (in_valid) begin
          if (!w_inMatch)     w_nextState = IDLE;
          else if (w_lastIdx) w_nextState = ROUND_END;
          else                w_nextState = IN_RD;
        end else if (w_timeout) begin
          w_nextState = IDLE;
        end
      end
      ROUND_END: w_nextState = (r_round == MAX_ROUND) ? IDLE : SHOW_RD;
      default:   w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_timerLoad      = 1'b0;
    w_timerLoadValue = '0;
    w_timerEnable    = 1'b0;
    case (r_state)
      SHOW_LAT: begin
        w_timerLoad      = 1'b1;
        w_timerLoadValue = SHOW_LOAD;
      end
      SHOW_ON: begin
        w_timerEnable    = 1'b1;
        w_timerLoad      = w_expired;
        w_timerLoadValue = GAP_LOAD;
      end
      SHOW_GAP: w_timerEnable = 1'b1;
      IN_RD: begin
        w_timerLoad      = 1'b1;
        w_timerLoadValue = TO_LOAD;
      end
      IN_WAIT:  w_timerEnable = 1'b1;
      default:  w_timerEnable = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx      <= '0;
      r_round    <= '0;
      r_disp     <= '0;
      r_expected <= '0;
      r_inFirst  <= 1'b0;
      r_genStart <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_genStart <= (r_state == IDLE) && start;
      r_win      <= (r_state == ROUND_END) && (r_round == MAX_ROUND);
      r_lose     <= (r_state == IN_WAIT) &&
                    ((in_valid && !w_inMatch) || (!in_valid && w_timeout));
      r_inFirst  <= (r_state == IN_RD);
      case (r_state)
        IDLE:     if (start) r_round <= (ADDR_W + 1)'(1);
        GEN:      if (gen_finish) r_idx <= '0;
        SHOW_LAT: r_disp <= mem_rdata;
        SHOW_GAP: if (w_expired) r_idx <= w_lastIdx ? '0 : r_idx + 1'b1;
        IN_WAIT: begin
          if (r_inFirst) r_expected <= mem_rdata;
          if (in_valid && w_inMatch && !w_lastIdx) r_idx <= r_idx + 1'b1;
        end
        ROUND_END: begin
          if (r_round != MAX_ROUND) begin
            r_round <= r_round + 1'b1;
            r_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd     = (r_state == SHOW_RD) || (r_state == IN_RD);
    mem_addr   = r_idx;
    disp_valid = (r_state == SHOW_ON);
    disp_value = disp_valid ? r_disp : '0;
    busy       = (r_state != IDLE);
    gen_start  = r_genStart;
    win        = r_win;
    lose       = r_lose;
    round      = r_round;
  end

endmodule

// File: tb/tb_sequence_round_ctrl.sv
// Bench for sequence_round_ctrl: start-up vector table, display scoreboard,
// full win game, mismatch, timeout, timeout/entry race and mid-show reset.
module tb_sequence_round_ctrl;

  localparam int MAXL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       genStart;
  logic       genFinish = 1'b0;
  logic [4:0] memAddr;
  logic       memRd;
  logic [3:0] memRdata = 4'h0;
  logic       dispValid;
  logic [3:0] dispValue;
  logic       inValid = 1'b0;
  logic [3:0] inValue = 4'h0;
  logic [5:0] round;
  logic       busy;
  logic       win;
  logic       lose;

  int testsRun = 0;
  int testsFailed = 0;
  int loseCount = 0;
  int winCount = 0;
  int correctEntries = 0;
  int runLen = 0;
  logic prevDisp = 1'b0;
  logic prevLose = 1'b0;
  logic prevWin = 1'b0;
  logic skipRun = 1'b0;

  logic [3:0] ramMem [32];
  logic [3:0] dispQ [$];

  typedef struct {
    logic       start;
    logic       genFinish;
    int         reps;
    logic       expGenStart;
    logic       expBusy;
    logic       expMemRd;
    logic [4:0] expAddr;
    logic       expDispValid;
    logic [3:0] expDispValue;
  } vec_t;

  vec_t vecs [5];

  sequence_round_ctrl #(
    .ADDR_W(5), .DATA_W(4), .MAX_LEN(MAXL),
    .SHOW_CYC(24), .GAP_CYC(8), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .gen_start(genStart), .gen_finish(genFinish),
    .mem_addr(memAddr), .mem_rd(memRd), .mem_rdata(memRdata),
    .disp_valid(dispValid), .disp_value(dispValue),
    .in_valid(inValid), .in_value(inValue),
    .round(round), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memRd) memRdata <= ramMem[memAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic g);
    start = s;
    genFinish = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Display scoreboard: each shown nibble must match the queued value and last 24 cycles.
  always @(negedge clk) begin
    logic [3:0] expV;
    if (dispValid && !prevDisp) begin
      checkOutput("dispQueued", dispQ.size() != 0, 1);
      if (dispQ.size() != 0) begin
        expV = dispQ.pop_front();
        checkOutput("dispValue", dispValue, expV);
      end
      runLen = 1;
    end else if (dispValid) begin
      runLen++;
    end else if (prevDisp) begin
      if (!skipRun) begin
        checkOutput("showCycles", runLen, 24);
        checkOutput("dispBlank", dispValue, 0);
      end
      skipRun = 1'b0;
    end
    if (prevLose) checkOutput("losePulseWidth", lose, 0);
    if (prevWin) checkOutput("winPulseWidth", win, 0);
    if (lose && !prevLose) loseCount++;
    if (win && !prevWin) winCount++;
    prevDisp = dispValid;
    prevLose = lose;
    prevWin = win;
  end

  task automatic waitInRd();
    int k = 0;
    while (!(memRd && dispQ.size() == 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("inRdSeen", memRd && dispQ.size() == 0, 1);
  endtask

  task automatic enterValue(input logic [3:0] v, input int delay);
    waitInRd();
    @(negedge clk);
    repeat (delay) @(negedge clk);
    inValid = 1'b1;
    inValue = v;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic playRound(input int n);
    for (int i = 0; i < n; i++) begin
      enterValue(ramMem[i], i % 3);
      correctEntries++;
    end
    if (n < MAXL) begin
      for (int i = 0; i <= n; i++) dispQ.push_back(ramMem[i]);
    end
    @(negedge clk);
    if (n < MAXL) checkOutput("roundAdvance", round, n + 1);
  endtask

  // Entries pulsed during GEN must be ignored.
  task automatic startGame();
    dispQ.push_back(ramMem[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    inValid = 1'b1;
    inValue = 4'h0;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    genFinish = 1'b1;
    @(negedge clk);
    genFinish = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("roundOne", round, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int loseBefore;
    int winBefore;

    for (int i = 0; i < 32; i++) ramMem[i] = 4'(i);
    ramMem[0] = 4'hA;
    ramMem[1] = 4'h3;
    ramMem[2] = 4'h7;
    ramMem[3] = 4'hC;

    vecs[0] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 1'b0, 50, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'h0};
    vecs[2] = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'h0};
    vecs[4] = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 4'hA};

    repeat (2) @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetWin", win, 0);
    checkOutput("resetLose", lose, 0);
    checkOutput("resetDisp", dispValid, 0);
    checkOutput("resetGenStart", genStart, 0);
    checkOutput("resetMemRd", memRd, 0);
    checkOutput("resetRound", round, 0);
    rst = 1'b1;

    // Start-up: gen_start pulse, 50-cycle generator wait, first read, first display.
    dispQ.push_back(ramMem[0]);
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        applyStimulus(vecs[v].start, vecs[v].genFinish);
        checkOutput($sformatf("vec%0d genStart", v), genStart, vecs[v].expGenStart);
        checkOutput($sformatf("vec%0d busy", v), busy, vecs[v].expBusy);
        checkOutput($sformatf("vec%0d memRd", v), memRd, vecs[v].expMemRd);
        if (vecs[v].expMemRd) checkOutput($sformatf("vec%0d memAddr", v), memAddr, vecs[v].expAddr);
        checkOutput($sformatf("vec%0d dispValid", v), dispValid, vecs[v].expDispValid);
        checkOutput($sformatf("vec%0d dispValue", v), dispValue, vecs[v].expDispValue);
      end
    end

    // Perfect game to MAX_LEN.
    for (int n = 1; n <= MAXL; n++) playRound(n);
    repeat (3) @(negedge clk);
    checkOutput("winCount", winCount, 1);
    checkOutput("noLose", loseCount, 0);
    checkOutput("correctEntries", correctEntries, 10);
    checkOutput("idleAfterWin", busy, 0);
    checkOutput("roundHoldsAfterWin", round, MAXL);

    // Mismatch on the second entry of round 2.
    startGame();
    playRound(1);
    loseBefore = loseCount;
    winBefore = winCount;
    enterValue(ramMem[0], 0);
    enterValue(4'h4, 1);
    repeat (2) @(negedge clk);
    checkOutput("mismatchLose", loseCount, loseBefore + 1);
    checkOutput("mismatchIdle", busy, 0);
    checkOutput("mismatchRound", round, 2);
    checkOutput("mismatchNoWin", winCount, winBefore);

    // Timeout with no input: lose exactly 1000 cycles after IN_WAIT entry.
    startGame();
    loseBefore = loseCount;
    waitInRd();
    @(negedge clk);
    cnt = 0;
    while (!lose && cnt < 1100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("timeoutCycles", cnt, 1000);
    repeat (2) @(negedge clk);
    checkOutput("timeoutLose", loseCount, loseBefore + 1);
    checkOutput("timeoutIdle", busy, 0);
    checkOutput("timeoutRound", round, 1);

    // Correct entry on the expiry cycle wins over the timeout.
    startGame();
    loseBefore = loseCount;
    enterValue(ramMem[0], 999);
    dispQ.push_back(ramMem[0]);
    dispQ.push_back(ramMem[1]);
    repeat (3) @(negedge clk);
    checkOutput("expiryNoLose", loseCount, loseBefore);
    checkOutput("expiryRound", round, 2);
    checkOutput("expiryBusy", busy, 1);

    // Reset for one cycle in the middle of SHOW_ON.
    cnt = 0;
    while (!dispValid && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("showSeen", dispValid, 1);
    @(negedge clk);
    loseBefore = loseCount;
    winBefore = winCount;
    skipRun = 1'b1;
    dispQ.delete();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDisp", dispValid, 0);
    checkOutput("midResetWin", win, 0);
    checkOutput("midResetLose", lose, 0);
    checkOutput("midResetRound", round, 0);
    checkOutput("midResetMemRd", memRd, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midResetNoLosePulse", loseCount, loseBefore);
    checkOutput("midResetNoWinPulse", winCount, winBefore);
    checkOutput("midResetStaysIdle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sequence_round_ctrl.md
Name: sequence_round_ctrl

Overview:
Game-round controller that sequences the pseudo-random sequence generator and its 32-entry pattern RAM. On start it triggers a fresh sequence generation, then runs rounds: it plays back the first N stored nibbles to the display and collects N player inputs, comparing each against RAM. It grows N by one per successful round until MAX_LEN is reached (win) or a mismatch or timeout occurs (lose). It sits between the top-level game FSM and the generator, display and input debouncer.

Parameters:
ADDR_W, 5, pattern RAM address width
DATA_W, 4, pattern nibble width
MAX_LEN, 32, rounds to win (1..2**ADDR_W)
SHOW_CYC, 24, cycles each nibble is shown on the display
GAP_CYC, 8, blank cycles between shown nibbles
TIMEOUT_CYC, 1000, max cycles waiting per player input; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  level; sampled in IDLE only
gen_start  out  1  one-cycle pulse to the sequence generator
gen_finish  in  1  one-cycle pulse from the generator when the RAM is filled
mem_addr  out  ADDR_W  pattern RAM read address
mem_rd  out  1  read strobe; data is valid on mem_rdata exactly 1 cycle later
mem_rdata  in  DATA_W  pattern RAM read data
disp_valid  out  1  high while a nibble is shown
disp_value  out  DATA_W  nibble shown; 0 when disp_valid is low
in_valid  in  1  one-cycle pulse per player entry
in_value  in  DATA_W  player nibble, qualified by in_valid
round  out  ADDR_W+1  current sequence length N (1..MAX_LEN)
busy  out  1  high in every state except IDLE
win  out  1  one-cycle pulse on completing round MAX_LEN
lose  out  1  one-cycle pulse on a mismatch or timeout

Behaviour:
- Reset (rst low at a posedge): state IDLE. All outputs 0. Internal index, timer and round cleared. Reset mid-operation aborts immediately, with no win or lose pulse.
- IDLE: when start is 1, pulse gen_start for 1 cycle and go to GEN. round is set to 1.
- GEN: wait for gen_finish. Ignore in_valid. On gen_finish, set idx=0 and go to SHOW_RD.
- SHOW_RD: mem_addr=idx, mem_rd=1 for 1 cycle, go to SHOW_LAT.
- SHOW_LAT: capture mem_rdata into the display register, go to SHOW_ON.
- SHOW_ON: disp_valid=1 for exactly SHOW_CYC cycles, then go to SHOW_GAP.
- SHOW_GAP: disp_valid=0 for GAP_CYC cycles. Then, if idx==round-1, set idx=0 and go to IN_RD; otherwise idx+1 and go to SHOW_RD.
- in_valid is ignored in all SHOW_* states.
- IN_RD: issue a read of idx (same 1-cycle latency), go to IN_WAIT.
- IN_WAIT: hold the expected nibble. The timeout counter starts on entry.
  - If in_valid and in_value==expected: when idx==round-1, go to ROUND_END; otherwise idx+1 and go to IN_RD.
  - If in_valid and in_value!=expected, or the timer reaches TIMEOUT_CYC (when nonzero): pulse lose and go to IDLE.
- ROUND_END: if round==MAX_LEN, pulse win and go to IDLE. Otherwise round+1, idx=0, and go to SHOW_RD.
- Simultaneous in_valid and timeout expiry on the same cycle: the input wins (compare it).
- in_valid arriving in the IN_RD cycle is dropped. The input side guarantees at least 2 cycles between pulses.
- Counter widths: idx is ADDR_W bits; round is ADDR_W+1 bits so that 32 is representable. The timer is sized by $clog2 of max(SHOW_CYC, GAP_CYC, TIMEOUT_CYC)+1.
- round holds its final value in IDLE until the next start.
- mem_rd is never high outside SHOW_RD and IN_RD.

Decomposition:
- Shared package: state enum (IDLE, GEN, SHOW_RD, SHOW_LAT, SHOW_ON, SHOW_GAP, IN_RD, IN_WAIT, ROUND_END) and the ADDR_W/DATA_W defaults, shared with the generator.
- One sub-module, round_timer: a loadable down-counter with load, enable and expired, reused for the SHOW, GAP and TIMEOUT intervals.

Test Plan:
- Reset mid-SHOW_ON with rst=0 for 1 cycle -> next cycle state IDLE, disp_valid=0, busy=0, no win or lose.
- start=1 -> gen_start high exactly 1 cycle. Hold gen_finish low for 50 cycles -> busy=1 and no mem_rd. Pulse gen_finish -> mem_rd at addr 0 on the next cycle.
- RAM preloaded with 0xA,0x3 and SHOW_CYC=24, GAP_CYC=8: round 1 -> disp_value=0xA for 24 cycles. Enter 0xA -> round=2, display shows 0xA then 0x3. Enter 0xA,0x3 -> round=3.
- Round 2 with the second entry 0x4 where 0x3 is expected -> lose pulse 1 cycle, state IDLE, round stays 2.
- TIMEOUT_CYC=1000 with no input -> lose exactly 1000 cycles after entering IN_WAIT. With in_valid on the expiry cycle and a correct value -> no lose.
- MAX_LEN=4 with perfect input for all rounds -> win pulse once after the 4th entry of round 4, never any lose, and 10 total correct entries.
